// File: rtl/parity_pkg.sv
// Shared constants for the UART parity generator/checker: parity mode
// codes, FSM state encoding and the final parity-bit selection.
package parity_pkg;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] CALC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Maps the raw XOR of the word onto the transmitted parity bit.
   // A disabled parity pass always yields 0.
   function automatic logic par_result(input logic       en,
                                       input logic [1:0] mode,
                                       input logic       raw_xor);
      logic res;
      res = 1'b0;
      if (en) begin
         case (mode)
            PAR_EVEN:  res = raw_xor;
            PAR_ODD:   res = ~raw_xor;
            PAR_MARK:  res = 1'b1;
            default:   res = 1'b0;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/parity_calc_gen.sv
// Parametrised parity generator/checker for the UART datapath.
// state | meaning
// IDLE  | no word captured since reset; waiting for a load
// CALC  | reducing the captured word (serial: one bit per clock)
// DONE  | par_bit/par_valid held; received parity may be checked
module parity_calc_gen
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SERIAL     = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] In_Data,
   input  logic                  Data_Valid,
   input  logic                  Busy_In,
   input  logic                  Par_En,
   input  logic [1:0]            Par_Mode,
   input  logic                  Chk_En,
   input  logic                  Rx_Par_Bit,
   output logic                  par_bit,
   output logic                  par_valid,
   output logic                  calc_busy,
   output logic                  par_err
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   logic [1:0]            state_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic                  acc_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  en_q;
   logic [1:0]            mode_q;

   logic load;
   logic calc_last;
   logic raw_xor;

   // A word is taken only while idle or holding a finished result.
   assign load = Data_Valid && !Busy_In && ((state_q == IDLE) || (state_q == DONE));

   generate
      if (SERIAL != 0) begin : g_serial
         // Last serial step folds the remaining LSB into the running XOR.
         assign calc_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));
         assign raw_xor   = acc_q ^ shreg_q[0];
      end else begin : g_parallel
         assign calc_last = 1'b1;
         assign raw_xor   = ^shreg_q;
      end
   endgenerate

   // FSM, shift/accumulate path and sticky checker; a load overrides a
   // coincident check in DONE.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         acc_q     <= 1'b0;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         mode_q    <= PAR_EVEN;
         par_bit   <= 1'b0;
         par_valid <= 1'b0;
         calc_busy <= 1'b0;
         par_err   <= 1'b0;
      end else begin
         case (state_q)
            CALC: begin
               shreg_q <= shreg_q >> 1;
               acc_q   <= acc_q ^ shreg_q[0];
               cnt_q   <= cnt_q + CNT_W'(1);
               if (calc_last) begin
                  par_bit   <= par_result(en_q, mode_q, raw_xor);
                  par_valid <= 1'b1;
                  calc_busy <= 1'b0;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (Chk_En && !load)
                  par_err <= par_err | (Rx_Par_Bit != par_bit);
            end
            IDLE: ;
            default: state_q <= IDLE;
         endcase

         if (load) begin
            shreg_q   <= In_Data;
            en_q      <= Par_En;
            mode_q    <= Par_Mode;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            par_valid <= 1'b0;
            par_err   <= 1'b0;
            calc_busy <= 1'b1;
            state_q   <= CALC;
         end
      end
   end

endmodule

// File: tb/tb_parity_calc_gen.sv
// Directed bench for parity_calc_gen: serial 8-bit, parallel 8-bit and
// serial 16-bit instances share the control inputs; each has its own load.
module tb_parity_calc_gen;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] in_data = '0;
   logic [2:0]  dv = '0;
   logic        busy_in = 1'b0;
   logic        par_en = 1'b1;
   logic [1:0]  par_mode = 2'b00;
   logic        chk_en = 1'b0;
   logic        rx_par_bit = 1'b0;

   wire [2:0] pb, pv, cb, pe;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int   which;
      logic exp_bit;
      int   exp_lat;
      int   load_cyc;
   } sb_item_t;

   sb_item_t sb_q[$];

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   parity_calc_gen #(.DATA_WIDTH(8), .SERIAL(1)) u_s8 (
      .CLK(CLK), .RST(RST), .In_Data(in_data[7:0]), .Data_Valid(dv[0]),
      .Busy_In(busy_in), .Par_En(par_en), .Par_Mode(par_mode),
      .Chk_En(chk_en), .Rx_Par_Bit(rx_par_bit),
      .par_bit(pb[0]), .par_valid(pv[0]), .calc_busy(cb[0]), .par_err(pe[0]));

   parity_calc_gen #(.DATA_WIDTH(8), .SERIAL(0)) u_p8 (
      .CLK(CLK), .RST(RST), .In_Data(in_data[7:0]), .Data_Valid(dv[1]),
      .Busy_In(busy_in), .Par_En(par_en), .Par_Mode(par_mode),
      .Chk_En(chk_en), .Rx_Par_Bit(rx_par_bit),
      .par_bit(pb[1]), .par_valid(pv[1]), .calc_busy(cb[1]), .par_err(pe[1]));

   parity_calc_gen #(.DATA_WIDTH(16), .SERIAL(1)) u_s16 (
      .CLK(CLK), .RST(RST), .In_Data(in_data), .Data_Valid(dv[2]),
      .Busy_In(busy_in), .Par_En(par_en), .Par_Mode(par_mode),
      .Chk_En(chk_en), .Rx_Par_Bit(rx_par_bit),
      .par_bit(pb[2]), .par_valid(pv[2]), .calc_busy(cb[2]), .par_err(pe[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic model_par(input int w, input logic [15:0] d,
                                      input logic en, input logic [1:0] m);
      logic x;
      x = 1'b0;
      for (int i = 0; i < w; i++) x ^= d[i];
      if (!en) return 1'b0;
      case (m)
         2'b00:   return x;
         2'b01:   return ~x;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Drives one load request for one cycle; the caller decides whether to expect a result.
   task automatic load(input int which, input logic [15:0] d, input logic en, input logic [1:0] m);
      in_data  = d;
      par_en   = en;
      par_mode = m;
      dv[which] = 1'b1;
      tick();
      dv[which] = 1'b0;
   endtask

   task automatic expect_result(input int which, input logic [15:0] d,
                                input logic en, input logic [1:0] m, input int lat);
      sb_item_t it;
      it.which    = which;
      it.exp_bit  = model_par((which == 2) ? 16 : 8, d, en, m);
      it.exp_lat  = lat;
      it.load_cyc = cyc;
      sb_q.push_back(it);
   endtask

   task automatic wait_result(input string tag);
      sb_item_t it;
      int n;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      it = sb_q.pop_front();
      n = 0;
      while (!pv[it.which] && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 32'(cyc - it.load_cyc), 32'(it.exp_lat));
      check({tag, "_bit"}, {31'd0, pb[it.which]}, {31'd0, it.exp_bit});
      check({tag, "_busy_done"}, {31'd0, cb[it.which]}, 32'd0);
   endtask

   initial begin
      RST = 1'b0;
      tick();
      tick();
      check("rst_par_bit", {29'd0, pb}, 32'd0);
      check("rst_par_valid", {29'd0, pv}, 32'd0);
      check("rst_calc_busy", {29'd0, cb}, 32'd0);
      check("rst_par_err", {29'd0, pe}, 32'd0);
      RST = 1'b1;
      tick();

      busy_in = 1'b1;
      load(0, 16'h00A5, 1'b1, 2'b00);
      busy_in = 1'b0;
      tick();
      check("busy_no_valid", {31'd0, pv[0]}, 32'd0);
      check("busy_no_calc", {31'd0, cb[0]}, 32'd0);

      load(0, 16'h00A5, 1'b1, 2'b00);
      expect_result(0, 16'h00A5, 1'b1, 2'b00, 8);
      check("s8_busy_after_load", {31'd0, cb[0]}, 32'd1);
      chk_en = 1'b1; rx_par_bit = 1'b1;
      tick();
      chk_en = 1'b0;
      check("chk_in_calc_ignored", {31'd0, pe[0]}, 32'd0);
      wait_result("s8_even_a5");

      chk_en = 1'b1; rx_par_bit = 1'b1;
      tick();
      chk_en = 1'b0;
      check("chk_mismatch_err", {31'd0, pe[0]}, 32'd1);
      chk_en = 1'b1; rx_par_bit = 1'b0;
      tick();
      chk_en = 1'b0;
      check("chk_sticky_err", {31'd0, pe[0]}, 32'd1);

      load(0, 16'h00A5, 1'b1, 2'b01);
      expect_result(0, 16'h00A5, 1'b1, 2'b01, 8);
      check("load_clears_err", {31'd0, pe[0]}, 32'd0);
      check("load_clears_valid", {31'd0, pv[0]}, 32'd0);
      wait_result("s8_odd_a5");

      load(1, 16'h0007, 1'b1, 2'b00);
      expect_result(1, 16'h0007, 1'b1, 2'b00, 1);
      wait_result("p8_even_07");
      load(1, 16'h0007, 1'b1, 2'b10);
      expect_result(1, 16'h0007, 1'b1, 2'b10, 1);
      wait_result("p8_mark");
      load(1, 16'h0007, 1'b1, 2'b11);
      expect_result(1, 16'h0007, 1'b1, 2'b11, 1);
      wait_result("p8_space");
      load(1, 16'h0006, 1'b0, 2'b01);
      expect_result(1, 16'h0006, 1'b0, 2'b01, 1);
      wait_result("p8_disabled");
      check("p8_disabled_valid", {31'd0, pv[1]}, 32'd1);

      load(2, 16'h8001, 1'b1, 2'b01);
      expect_result(2, 16'h8001, 1'b1, 2'b01, 16);
      tick(); tick(); tick(); tick();
      in_data = 16'hFFFF; par_mode = 2'b00; par_en = 1'b0;
      dv[2] = 1'b1;
      tick();
      dv[2] = 1'b0;
      wait_result("s16_odd_8001");
      for (int i = 0; i < 20; i++) tick();
      check("s16_dropped_no_rerun", {31'd0, cb[2]}, 32'd0);
      check("s16_result_held", {31'd0, pb[2]}, 32'd1);

      load(0, 16'h0001, 1'b1, 2'b00);
      tick(); tick();
      RST = 1'b0;
      tick();
      check("midrst_valid", {31'd0, pv[0]}, 32'd0);
      check("midrst_busy", {31'd0, cb[0]}, 32'd0);
      check("midrst_bit", {31'd0, pb[0]}, 32'd0);
      RST = 1'b1;
      tick();
      tick();
      check("midrst_no_result", {31'd0, pv[0]}, 32'd0);

      load(0, 16'h0001, 1'b1, 2'b00);
      expect_result(0, 16'h0001, 1'b1, 2'b00, 8);
      wait_result("s8_after_rst");

      chk_en = 1'b1; rx_par_bit = 1'b0;
      load(0, 16'h0003, 1'b1, 2'b00);
      chk_en = 1'b0;
      expect_result(0, 16'h0003, 1'b1, 2'b00, 8);
      check("load_beats_chk", {31'd0, pe[0]}, 32'd0);
      wait_result("s8_even_03");
      check("chk_discarded_err", {31'd0, pe[0]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
